subtractors_tree_pipe: RTL and testbench
========================================

SUBTRACTORS_TREE_PIPE -- requirements
Module: subtractors_tree_pipe

Interface
REQ-001 Parameter: CNT_W, default 8, width of the accepted-result counter.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operand set a/b/c/d is valid this cycle.
REQ-005 Port: in_ready  output  1  block accepts an operand set this cycle.
REQ-006 Port: a  input  4  unsigned operand.
REQ-007 Port: b  input  4  unsigned operand.
REQ-008 Port: c  input  8  unsigned operand.
REQ-009 Port: d  input  8  unsigned operand.
REQ-010 Port: out_valid  output  1  diff1/diff2/diff3 are valid.
REQ-011 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-012 Port: diff1  output  5  signed two's complement, a - b.
REQ-013 Port: diff2  output  9  signed two's complement, c - d.
REQ-014 Port: diff3  output  10  signed two's complement, diff2 - diff1.
REQ-015 Port: neg  output  3  sign flags {diff3<0, diff2<0, diff1<0}.
REQ-016 Port: out_count  output  CNT_W  number of accepted results, modulo 2^CNT_W.

Function
REQ-017 An input transfer SHALL occur only on a rising edge where in_valid=1 and in_ready=1.
REQ-018 An output transfer SHALL occur only on a rising edge where out_valid=1 and out_ready=1.
REQ-019 The block SHALL be a two-stage pipeline, each stage holding a valid bit (v1, v2).
REQ-020 Stage 1 SHALL register diff1 = zero-extended a minus zero-extended b (5 bits) and diff2 = c - d (9 bits) on an input transfer.
REQ-021 Stage 2 SHALL register diff3 = sign-extended diff2 minus sign-extended diff1 (10 bits), pass diff1/diff2 through, and derive neg from the MSBs.
REQ-022 Results SHALL never overflow: diff1 in [-15,15], diff2 in [-255,255], diff3 in [-270,270].
REQ-023 Stage 2 load enable SHALL be ld2 = v1 & (~v2 | out_ready).
REQ-024 Stage 1 load enable SHALL be ld1 = in_valid & in_ready.
REQ-025 in_ready SHALL equal ~v1 | ~v2 | out_ready, combinationally.
REQ-026 On each edge, v1 SHALL become ld1 | (v1 & ~ld2).
REQ-027 On each edge, v2 SHALL become ld2 | (v2 & ~out_ready).
REQ-028 out_valid SHALL equal v2.
REQ-029 Latency SHALL be 2 cycles: data accepted at edge N is presented with out_valid=1 after edge N+1 when there is no backpressure.
REQ-030 Throughput SHALL be one result per cycle while out_ready=1.
REQ-031 While out_valid=1 and out_ready=0, diff1/diff2/diff3/neg SHALL hold stable.
REQ-032 Once both stages are full and out_ready=0, in_ready SHALL be 0.
REQ-033 No result SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-034 Simultaneous input and output transfers in one cycle SHALL both complete.
REQ-035 out_count SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-036 Data registers SHALL load only when their stage load enable is 1.

Reset
REQ-037 While rst_n=0, v1, v2, out_valid, diff1, diff2, diff3, neg and out_count SHALL be 0, regardless of clk.
REQ-038 Assertion of rst_n mid-operation SHALL discard all in-flight results.
REQ-039 After rst_n deasserts, in_ready SHALL be 1 and the first transfer SHALL be accepted on the next rising edge.

Verification
REQ-040 Vector 1: a=0, b=3, c=1, d=255, out_ready=1 -> 2 cycles later diff1=-3, diff2=-254, diff3=-251, neg=3'b111.
REQ-041 Vector 2: a=10, b=13, c=9, d=10 -> diff1=-3, diff2=-1, diff3=2, neg=3'b011.
REQ-042 Extreme: a=15, b=0, c=0, d=255 -> diff3=-270; a=15, b=0, c=255, d=0 -> diff3=240, neg=3'b000.
REQ-043 Backpressure: stream 4 sets with out_ready=0 -> in_ready falls after 2 accepted; out_ready=1 then drains all 4 in order with no loss; out_count=4.
REQ-044 Random in_valid/out_ready over 1000 sets -> scoreboard matches in order; out_count wraps correctly at 256.
REQ-045 rst_n pulsed low with both stages full -> out_valid=0 and out_count=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/subtractors_tree_pipe.sv
// subtractors_tree_pipe: two-stage valid/ready pipeline computing a-b, c-d and their signed difference
module subtractors_tree_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [7:0]       c,
  input  logic [7:0]       d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       diff1,
  output logic [8:0]       diff2,
  output logic [9:0]       diff3,
  output logic [2:0]       neg,
  output logic [CNT_W-1:0] out_count
);
  logic             v1_q, v1_d, v2_q, v2_d;
  logic [4:0]       s1_diff1_q, s1_diff1_d, diff1_q;
  logic [8:0]       s1_diff2_q, s1_diff2_d, diff2_q;
  logic [9:0]       diff3_q, diff3_d;
  logic [2:0]       neg_q, neg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ld1, ld2;
  // Handshake, load enables and next-state values for both stages and the counter
  always_comb begin
    in_ready   = ~v1_q | ~v2_q | out_ready;
    ld1        = in_valid & in_ready;
    ld2        = v1_q & (~v2_q | out_ready);
    v1_d       = ld1 | (v1_q & ~ld2);
    v2_d       = ld2 | (v2_q & ~out_ready);
    s1_diff1_d = {1'b0, a} - {1'b0, b};
    s1_diff2_d = {1'b0, c} - {1'b0, d};
    diff3_d    = {s1_diff2_q[8], s1_diff2_q} - {{5{s1_diff1_q[4]}}, s1_diff1_q};
    neg_d      = {diff3_d[9], s1_diff2_q[8], s1_diff1_q[4]};
    count_d    = (v2_q & out_ready) ? count_q + 1'b1 : count_q;
  end
  // Valid bits, stage data and accepted-result counter; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      s1_diff1_q <= '0;
      s1_diff2_q <= '0;
      diff1_q    <= '0;
      diff2_q    <= '0;
      diff3_q    <= '0;
      neg_q      <= '0;
      count_q    <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      count_q <= count_d;
      if (ld1) begin
        s1_diff1_q <= s1_diff1_d;
        s1_diff2_q <= s1_diff2_d;
      end
      if (ld2) begin
        diff1_q <= s1_diff1_q;
        diff2_q <= s1_diff2_q;
        diff3_q <= diff3_d;
        neg_q   <= neg_d;
      end
    end
  end
  assign out_valid = v2_q;
  assign diff1     = diff1_q;
  assign diff2     = diff2_q;
  assign diff3     = diff3_q;
  assign neg       = neg_q;
  assign out_count = count_q;
endmodule

// File: tb/tb_subtractors_tree_pipe.sv
// tb_subtractors_tree_pipe: table vectors, backpressure/reset sequences and random scoreboard run
module tb_subtractors_tree_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0, b = '0;
  logic [7:0] c = '0, d = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] diff1;
  logic [8:0] diff2;
  logic [9:0] diff3;
  logic [2:0] neg;
  logic [7:0] out_count;

  subtractors_tree_pipe #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .diff1(diff1), .diff2(diff2), .diff3(diff3), .neg(neg), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d1;
    int d2;
    int d3;
    int ng;
  } res_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] c;
    logic [7:0] d;
    int d1;
    int d2;
    int d3;
    int ng;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  int   cnt_m = 0;
  logic acc;
  logic held = 1'b0;
  res_t snap;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic res_t model(input logic [3:0] ia, ib, input logic [7:0] ic, id);
    res_t r;
    r.d1 = int'(ia) - int'(ib);
    r.d2 = int'(ic) - int'(id);
    r.d3 = r.d2 - r.d1;
    r.ng = (r.d3 < 0 ? 4 : 0) + (r.d2 < 0 ? 2 : 0) + (r.d1 < 0 ? 1 : 0);
    return r;
  endfunction

  // One clock cycle: drive, check handshake and scoreboard before the edge, check counter after it
  task automatic cyc(input logic iv, input logic [3:0] ia, ib, input logic [7:0] ic, id, input logic ordy);
    res_t e;
    int   occ;
    in_valid = iv; a = ia; b = ib; c = ic; d = id; out_ready = ordy;
    #1;
    occ = q.size();
    if (occ >= 2 || !ordy) chk("in_ready", int'(in_ready), int'(occ < 2 || ordy));
    acc = in_valid && in_ready;
    if (held) begin
      chk("hold_diff1", int'($signed(diff1)), snap.d1);
      chk("hold_diff2", int'($signed(diff2)), snap.d2);
      chk("hold_diff3", int'($signed(diff3)), snap.d3);
    end
    held = out_valid && !out_ready;
    snap.d1 = int'($signed(diff1)); snap.d2 = int'($signed(diff2)); snap.d3 = int'($signed(diff3));
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_diff1", int'($signed(diff1)), e.d1);
        chk("sb_diff2", int'($signed(diff2)), e.d2);
        chk("sb_diff3", int'($signed(diff3)), e.d3);
        chk("sb_neg", int'(neg), e.ng);
        cnt_m = (cnt_m + 1) % 256;
      end
    end
    if (acc) q.push_back(model(ia, ib, ic, id));
    @(posedge clk);
    #1;
    chk("out_count", int'(out_count), cnt_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    logic [3:0] ba[4], bb[4];
    logic [7:0] bc[4], bd[4];
    int n_acc, cnt0, sent, bud;
    tbl[0] = '{4'd0, 4'd3, 8'd1, 8'd255, -3, -254, -251, 7};
    tbl[1] = '{4'd10, 4'd13, 8'd9, 8'd10, -3, -1, 2, 3};
    tbl[2] = '{4'd15, 4'd0, 8'd0, 8'd255, 15, -255, -270, 6};
    tbl[3] = '{4'd15, 4'd0, 8'd255, 8'd0, 15, 255, 240, 0};

    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_diff3", int'(diff3), 0);
    chk("rst_neg", int'(neg), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, 1'b1);
      chk("tbl_accept", int'(acc), 1);
      cyc(1'b0, 4'd0, 4'd0, 8'd0, 8'd0, 1'b1);
      chk("tbl_out_valid", int'(out_valid), 1);
      chk("tbl_diff1", int'($signed(diff1)), tbl[i].d1);
      chk("tbl_diff2", int'($signed(diff2)), tbl[i].d2);
      chk("tbl_diff3", int'($signed(diff3)), tbl[i].d3);
      chk("tbl_neg", int'(neg), tbl[i].ng);
      cyc(1'b0, 4'd0, 4'd0, 8'd0, 8'd0, 1'b1);
      chk("tbl_drained", int'(out_valid), 0);
    end

    for (int i = 0; i < 4; i++) begin
      ba[i] = 4'($urandom); bb[i] = 4'($urandom); bc[i] = 8'($urandom); bd[i] = 8'($urandom);
    end
    cnt0 = cnt_m;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, ba[n_acc], bb[n_acc], bc[n_acc], bd[n_acc], 1'b0);
      if (acc) n_acc++;
    end
    chk("bp_accepted", n_acc, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    bud = 0;
    while (n_acc < 4 && bud < 20) begin
      cyc(1'b1, ba[n_acc], bb[n_acc], bc[n_acc], bd[n_acc], 1'b1);
      if (acc) n_acc++;
      bud++;
    end
    chk("bp_all_accepted", n_acc, 4);
    bud = 0;
    while (q.size() > 0 && bud < 20) begin
      cyc(1'b0, 4'd0, 4'd0, 8'd0, 8'd0, 1'b1);
      bud++;
    end
    chk("bp_drained", q.size(), 0);
    chk("bp_count", int'(out_count), (cnt0 + 4) % 256);

    sent = 0;
    bud = 0;
    while (sent < 1000 && bud < 20000) begin
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
          1'($urandom_range(0, 9) < 7));
      if (acc) sent++;
      bud++;
    end
    chk("rnd_sent", sent, 1000);
    bud = 0;
    while (q.size() > 0 && bud < 20) begin
      cyc(1'b0, 4'd0, 4'd0, 8'd0, 8'd0, 1'b1);
      bud++;
    end
    chk("rnd_drained", q.size(), 0);

    cyc(1'b1, 4'd5, 4'd1, 8'd7, 8'd2, 1'b0);
    cyc(1'b1, 4'd6, 4'd2, 8'd9, 8'd3, 1'b0);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_out_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_count", int'(out_count), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    q.delete();
    cnt_m = 0;
    held = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'd0, 4'd0, 8'd0, 8'd0, 1'b1);
      chk("post_rst_no_stale", int'(out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
